// File: rtl/packet_tx_scheduler.sv
// Two-requester round-robin scheduler that launches one packet at a time and enforces the inter-packet gap.
// Define PACKET_TX_SCHEDULER_STATS_EN to build the pkt_count packet counter (otherwise it reads constant 0).
module packet_tx_scheduler #(
  parameter int IPG_CYCLES    = 48,
  parameter int START_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [15:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [15:0] req1_data,
  output logic        req1_ready,
  output logic [15:0] tx_data,
  output logic        tx_start,
  input  logic        txen,
  output logic        busy,
  output logic        timeout_err,
  output logic [15:0] pkt_count
);

  localparam int CNT_MAX = (IPG_CYCLES > START_TIMEOUT) ? IPG_CYCLES : START_TIMEOUT;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(START_TIMEOUT - 1);
  localparam logic [CW-1:0] GAP_LAST     = CW'(IPG_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_TXEN, SENDING, GAP} state_t;

  state_t        state, next_state;
  logic [CW-1:0] cnt;
  logic          prio;
  logic          grant_valid, grant_sel, timeout_hit;

  // A lone valid requester wins outright; the pointer only breaks ties.
  always_comb begin
    grant_valid = req0_valid | req1_valid;
    grant_sel   = (req0_valid & req1_valid) ? prio : req1_valid;
    timeout_hit = (state == WAIT_TXEN) && !txen && (cnt == TIMEOUT_LAST);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      prio        <= 1'b0;
      tx_data     <= '0;
      busy        <= 1'b0;
    end else begin
      state <= next_state;
      busy  <= (next_state != IDLE);
      if ((next_state == state) && ((state == WAIT_TXEN) || (state == GAP)))
        cnt <= cnt + 1'b1;
      else
        cnt <= '0;
      if ((state == IDLE) && grant_valid) begin
        tx_data <= grant_sel ? req1_data : req0_data;
        prio    <= ~grant_sel;
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (grant_valid) next_state = LAUNCH;
      LAUNCH:    next_state = WAIT_TXEN;
      WAIT_TXEN: begin
        if (txen)             next_state = SENDING;
        else if (timeout_hit) next_state = GAP;
      end
      SENDING:   if (!txen) next_state = GAP;
      GAP:       if (cnt == GAP_LAST) next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // Ready and the timeout pulse are gated by reset so nothing leaks out while it is held.
  always_comb begin
    tx_start    = (state == LAUNCH);
    req0_ready  = rst && (state == IDLE) && req0_valid && !grant_sel;
    req1_ready  = rst && (state == IDLE) && req1_valid && grant_sel;
    timeout_err = rst && timeout_hit;
  end

`ifdef PACKET_TX_SCHEDULER_STATS_EN
  logic [15:0] pkt_count_q;

  always_ff @(posedge clk) begin
    if (!rst)
      pkt_count_q <= '0;
    else if ((state == SENDING) && !txen)
      pkt_count_q <= pkt_count_q + 16'd1;
  end

  assign pkt_count = pkt_count_q;
`else
  assign pkt_count = '0;
`endif

endmodule

// File: tb/tb_packet_tx_scheduler.sv
// Directed bench for packet_tx_scheduler: reset, single packet, arbitration, start timeout, mid-packet reset, counter wrap.
module tb_packet_tx_scheduler;

  localparam int IPG = 48;
`ifdef PACKET_TX_SCHEDULER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0, txen = 1'b0;
  logic [15:0] req0_data = '0, req1_data = '0;
  logic        req0_ready, req1_ready, tx_start, busy, timeout_err;
  logic [15:0] tx_data, pkt_count;

  int tests_run = 0, tests_failed = 0;
  int start_cnt = 0, hs0_cnt = 0, hs1_cnt = 0, to_cnt = 0;
  int grant_q[$];

  packet_tx_scheduler #(.IPG_CYCLES(IPG), .START_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .tx_data(tx_data), .tx_start(tx_start), .txen(txen), .busy(busy),
    .timeout_err(timeout_err), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  // Event monitor: values seen here are the ones the DUT acts on at this edge.
  always @(posedge clk) begin
    if (tx_start) start_cnt++;
    if (req0_valid && req0_ready) begin hs0_cnt++; grant_q.push_back(0); end
    if (req1_valid && req1_ready) begin hs1_cnt++; grant_q.push_back(1); end
    if (timeout_err) to_cnt++;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic wait_start(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (tx_start) seen = 1'b1;
    end
  endtask

  // Transmitter model, entered on the LAUNCH-cycle negedge.
  task automatic run_txen(input int rise, input int high);
    repeat (rise) @(negedge clk);
    txen = 1'b1;
    repeat (high) @(negedge clk);
    txen = 1'b0;
  endtask

  task automatic wait_idle(output int hi);
    hi = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (busy) hi++;
      else break;
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1; txen = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy: got %0b, expected 0", busy); end
    tests_run++; if (tx_start !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_tx_start: got %0b, expected 0", tx_start); end
    tests_run++; if (tx_data !== 16'h0000) begin tests_failed++; $display("[TB] FAIL reset_tx_data: got %0h, expected 0", tx_data); end
    tests_run++; if (timeout_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_timeout_err: got %0b, expected 0", timeout_err); end
    tests_run++; if (pkt_count !== 16'h0000) begin tests_failed++; $display("[TB] FAIL reset_pkt_count: got %0h, expected 0", pkt_count); end
    tests_run++; if ({req0_ready, req1_ready} !== 2'b00) begin tests_failed++; $display("[TB] FAIL reset_ready: got %b, expected 00", {req0_ready, req1_ready}); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single;
    int s0, h0, hi;
    s0 = start_cnt; h0 = hs0_cnt;
    req0_data = 16'hBEEF; req0_valid = 1'b1;
    #1;
    tests_run++; if ({req0_ready, req1_ready} !== 2'b10) begin tests_failed++; $display("[TB] FAIL single_ready: got %b, expected 10", {req0_ready, req1_ready}); end
    @(negedge clk);
    req0_valid = 1'b0;
    tests_run++; if (tx_start !== 1'b1) begin tests_failed++; $display("[TB] FAIL single_launch: got %0b, expected 1", tx_start); end
    tests_run++; if (tx_data !== 16'hBEEF) begin tests_failed++; $display("[TB] FAIL single_tx_data: got %0h, expected beef", tx_data); end
    run_txen(3, 298);
    wait_idle(hi);
    tests_run++; if (hi !== IPG) begin tests_failed++; $display("[TB] FAIL single_gap: got %0d, expected %0d", hi, IPG); end
    tests_run++; if (start_cnt - s0 !== 1) begin tests_failed++; $display("[TB] FAIL single_start_pulses: got %0d, expected 1", start_cnt - s0); end
    tests_run++; if (hs0_cnt - h0 !== 1) begin tests_failed++; $display("[TB] FAIL single_handshakes: got %0d, expected 1", hs0_cnt - h0); end
    tests_run++; if (pkt_count !== (STATS ? 16'd1 : 16'd0)) begin tests_failed++; $display("[TB] FAIL single_pkt_count: got %0d, expected %0d", pkt_count, STATS ? 1 : 0); end
    tests_run++; if (tx_data !== 16'hBEEF) begin tests_failed++; $display("[TB] FAIL single_hold: got %0h, expected beef", tx_data); end
  endtask

  // txen rises on the last allowed wait cycle: it must win over the timeout.
  task automatic test_final_cycle;
    int t0, hi;
    t0 = to_cnt;
    req0_data = 16'h1234; req0_valid = 1'b1;
    #1;
    tests_run++; if (req0_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL lone_req0_ready: got %0b, expected 1", req0_ready); end
    @(negedge clk);
    req0_valid = 1'b0;
    run_txen(15, 5);
    wait_idle(hi);
    tests_run++; if (to_cnt - t0 !== 0) begin tests_failed++; $display("[TB] FAIL final_cycle_timeout: got %0d, expected 0", to_cnt - t0); end
    tests_run++; if (hi !== IPG) begin tests_failed++; $display("[TB] FAIL final_cycle_gap: got %0d, expected %0d", hi, IPG); end
    tests_run++; if (pkt_count !== (STATS ? 16'd2 : 16'd0)) begin tests_failed++; $display("[TB] FAIL final_cycle_pkt_count: got %0d, expected %0d", pkt_count, STATS ? 2 : 0); end
  endtask

  task automatic test_timeout;
    int t0, k, hi;
    t0 = to_cnt; k = 0;
    req1_data = 16'h5A5A; req1_valid = 1'b1;
    #1;
    tests_run++; if ({req0_ready, req1_ready} !== 2'b01) begin tests_failed++; $display("[TB] FAIL lone_req1_ready: got %b, expected 01", {req0_ready, req1_ready}); end
    @(negedge clk);
    req1_valid = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (timeout_err) begin k = i; break; end
    end
    tests_run++; if (k !== 15) begin tests_failed++; $display("[TB] FAIL timeout_latency: got %0d, expected 15", k); end
    wait_idle(hi);
    tests_run++; if (hi !== IPG) begin tests_failed++; $display("[TB] FAIL timeout_gap: got %0d, expected %0d", hi, IPG); end
    tests_run++; if (to_cnt - t0 !== 1) begin tests_failed++; $display("[TB] FAIL timeout_pulses: got %0d, expected 1", to_cnt - t0); end
    tests_run++; if (pkt_count !== (STATS ? 16'd2 : 16'd0)) begin tests_failed++; $display("[TB] FAIL timeout_pkt_count: got %0d, expected %0d", pkt_count, STATS ? 2 : 0); end
    tests_run++; if (tx_data !== 16'h5A5A) begin tests_failed++; $display("[TB] FAIL timeout_tx_data: got %0h, expected 5a5a", tx_data); end
  endtask

  task automatic test_contention;
    bit seen;
    int hi;
    logic [15:0] exp_data;
    grant_q.delete();
    rst = 1'b0; req0_data = 16'h0001; req1_data = 16'h0002;
    req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int p = 0; p < 4; p++) begin
      wait_start(seen);
      tests_run++; if (!seen) begin tests_failed++; $display("[TB] FAIL contention_start%0d: got no tx_start, expected one", p); break; end
      exp_data = (p % 2 == 0) ? 16'h0001 : 16'h0002;
      tests_run++; if (tx_data !== exp_data) begin tests_failed++; $display("[TB] FAIL contention_data%0d: got %0h, expected %0h", p, tx_data, exp_data); end
      run_txen(2, 10);
      if (p == 3) begin req0_valid = 1'b0; req1_valid = 1'b0; end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_idle(hi);
    tests_run++; if (grant_q.size() !== 4) begin tests_failed++; $display("[TB] FAIL contention_grant_count: got %0d, expected 4", grant_q.size()); end
    for (int i = 0; i < grant_q.size() && i < 4; i++) begin
      tests_run++; if (grant_q[i] !== i % 2) begin tests_failed++; $display("[TB] FAIL contention_grant%0d: got %0d, expected %0d", i, grant_q[i], i % 2); end
    end
    tests_run++; if (pkt_count !== (STATS ? 16'd4 : 16'd0)) begin tests_failed++; $display("[TB] FAIL contention_pkt_count: got %0d, expected %0d", pkt_count, STATS ? 4 : 0); end
  endtask

  task automatic test_reset_mid;
    int t0, hi;
    rst = 1'b0; repeat (2) @(negedge clk); rst = 1'b1;
    req0_data = 16'hCAFE; req0_valid = 1'b1;
    @(negedge clk);
    req0_valid = 1'b0;
    run_txen(2, 5);
    txen = 1'b1;
    t0 = to_cnt;
    rst = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
    req0_data = 16'h1111; req1_data = 16'h2222;
    #1;
    tests_run++; if ({req0_ready, req1_ready} !== 2'b00) begin tests_failed++; $display("[TB] FAIL midreset_ready: got %b, expected 00", {req0_ready, req1_ready}); end
    @(negedge clk);
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL midreset_busy: got %0b, expected 0", busy); end
    tests_run++; if (tx_start !== 1'b0) begin tests_failed++; $display("[TB] FAIL midreset_tx_start: got %0b, expected 0", tx_start); end
    tests_run++; if (tx_data !== 16'h0000) begin tests_failed++; $display("[TB] FAIL midreset_tx_data: got %0h, expected 0", tx_data); end
    tests_run++; if (pkt_count !== 16'h0000) begin tests_failed++; $display("[TB] FAIL midreset_pkt_count: got %0d, expected 0", pkt_count); end
    rst = 1'b1; txen = 1'b0;
    #1;
    tests_run++; if ({req0_ready, req1_ready} !== 2'b10) begin tests_failed++; $display("[TB] FAIL midreset_priority: got %b, expected 10", {req0_ready, req1_ready}); end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    tests_run++; if (tx_data !== 16'h1111) begin tests_failed++; $display("[TB] FAIL midreset_regrant_data: got %0h, expected 1111", tx_data); end
    run_txen(1, 4);
    wait_idle(hi);
    tests_run++; if (to_cnt - t0 !== 0) begin tests_failed++; $display("[TB] FAIL midreset_timeout: got %0d, expected 0", to_cnt - t0); end
    tests_run++; if (pkt_count !== (STATS ? 16'd1 : 16'd0)) begin tests_failed++; $display("[TB] FAIL midreset_pkt_count_after: got %0d, expected %0d", pkt_count, STATS ? 1 : 0); end
  endtask

`ifdef PACKET_TX_SCHEDULER_STATS_EN
  task automatic test_wrap;
    int hi;
    force dut.pkt_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.pkt_count_q;
    @(negedge clk);
    tests_run++; if (pkt_count !== 16'hFFFF) begin tests_failed++; $display("[TB] FAIL wrap_preload: got %0h, expected ffff", pkt_count); end
    req1_data = 16'h0F0F; req1_valid = 1'b1;
    @(negedge clk);
    req1_valid = 1'b0;
    run_txen(2, 6);
    wait_idle(hi);
    tests_run++; if (pkt_count !== 16'h0000) begin tests_failed++; $display("[TB] FAIL wrap_pkt_count: got %0h, expected 0", pkt_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_final_cycle();
    test_timeout();
    test_contention();
    test_reset_mid();
`ifdef PACKET_TX_SCHEDULER_STATS_EN
    test_wrap();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/packet_tx_scheduler.md
PACKET_TX_SCHEDULER -- requirements
Module: packet_tx_scheduler

Interface
REQ-001 SHALL have parameter IPG_CYCLES, default 48, meaning the inter-packet gap in clk cycles after txen falls (96 bit times at 2 bits/cycle).
REQ-002 SHALL have parameter START_TIMEOUT, default 15, meaning the maximum cycles between the start pulse and txen rising.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-005 SHALL have ports req0_valid / req1_valid  input  1  requester has a 16-bit word to send.
REQ-006 SHALL have ports req0_data / req1_data  input  16  payload word per requester.
REQ-007 SHALL have ports req0_ready / req1_ready  output  1  word accepted when valid and ready are both high.
REQ-008 SHALL have port tx_data  output  16  payload word presented to the packet transmitter.
REQ-009 SHALL have port tx_start  output  1  one-cycle launch pulse to the packet transmitter.
REQ-010 SHALL have port txen  input  1  transmit-enable fed back from the packet transmitter.
REQ-011 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-012 SHALL have port timeout_err  output  1  one-cycle pulse when txen fails to rise within START_TIMEOUT.
REQ-013 SHALL have port pkt_count  output  16  count of packets completed.

Function
REQ-014 SHALL implement the states IDLE, LAUNCH, WAIT_TXEN, SENDING and GAP.
REQ-015 IDLE: reqN_ready SHALL be combinationally high only for the round-robin winner among valid requesters; on handshake, latch the data into tx_data, record the winner, and go to LAUNCH.
REQ-016 Round-robin: after granting requester N, requester (N+1) mod 2 SHALL have priority; after reset requester 0 SHALL have priority.
REQ-017 A lone valid requester SHALL be granted regardless of the priority pointer.
REQ-018 reqN_ready SHALL be low in every state other than IDLE.
REQ-019 LAUNCH: tx_start SHALL be high for exactly that one cycle; tx_data SHALL be held stable from the latch until the next IDLE handshake; next state is WAIT_TXEN.
REQ-020 WAIT_TXEN: the controller SHALL count cycles from 0.
- txen=1: go to SENDING.
- count reaches START_TIMEOUT-1 with txen=0: pulse timeout_err for one cycle and go to GAP.
- txen=1 on the final count cycle: txen wins; no error.
REQ-021 SENDING: on txen=0 the controller SHALL go to GAP, and pkt_count SHALL increment by 1 (mod 2^16, wrapping 0xFFFF to 0x0000).
REQ-022 GAP: the controller SHALL hold for exactly IPG_CYCLES cycles, then go to IDLE; txen activity in GAP SHALL be ignored.
REQ-023 tx_start SHALL be low in every state except LAUNCH, which guarantees a rising edge per packet.
REQ-024 Minimum spacing of tx_start pulses SHALL be 1 + (cycles to txen rise) + (txen high cycles) + IPG_CYCLES + 1.
REQ-025 busy SHALL be registered from the state, with no combinational path from inputs.

Reset
REQ-026 While rst=0 at a clk edge, the block SHALL take the following values:
- state=IDLE
- tx_start=0, tx_data=0
- timeout_err=0, pkt_count=0
- round-robin priority = requester 0
- all counters = 0
REQ-027 When rst is sampled low mid-packet (any state), the block SHALL abort and take the values of REQ-026 next cycle; no pkt_count increment and no timeout_err pulse.
REQ-028 reqN_ready SHALL be 0 during reset.

Configuration
REQ-029 With PACKET_TX_SCHEDULER_STATS_EN defined, pkt_count SHALL operate per REQ-021.
REQ-030 Without PACKET_TX_SCHEDULER_STATS_EN, pkt_count SHALL be constant 0 and its counter register SHALL not be synthesised; all other behaviour is unchanged.

Verification
REQ-031 Single request: req0_valid=1, data=0xBEEF; the model raises txen 3 cycles after tx_start and holds it for 298 cycles -> req0_ready for 1 cycle, tx_data=0xBEEF, one tx_start pulse, busy low exactly 48 cycles after txen falls, pkt_count=1 (STATS_EN).
REQ-032 Contention: both valid from reset, data 0x0001/0x0002, held continuously -> grants alternate 0,1,0,1 across 4 packets with tx_data sequence 0x0001,0x0002,0x0001,0x0002.
REQ-033 Timeout: txen held at 0 -> timeout_err pulses once exactly 15 cycles after LAUNCH, the state passes through a 48-cycle GAP to IDLE, and pkt_count is unchanged.
REQ-034 Reset mid-SENDING: rst=0 for 1 cycle while txen=1 -> next cycle busy=0, tx_start=0, pkt_count unchanged; a new request is then granted to requester 0.
REQ-035 Wrap: preload pkt_count to 0xFFFF by force and complete one packet -> pkt_count=0x0000.
REQ-036 Build without PACKET_TX_SCHEDULER_STATS_EN and run the REQ-031 scenario -> identical tx_start and busy timing, pkt_count constant 0.
